bcd_scan_decoder: RTL
=====================

Name: bcd_scan_decoder

Overview:
- Multi-digit, time-multiplexed BCD decoder.
- Captures a packed DIGITS-wide BCD word into a shadow register and scans the digits one at a time.
- For each scanned digit, drives a one-hot digit select and a one-hot 0..9 decode, with invalid-code detection and optional leading-zero blanking.
- Sits between the counter/arithmetic datapath and the display/LED drive logic.

Parameters:
- DIGITS, 4: number of BCD digits scanned. Must be ≥1.
- SCAN_DIV, 16: clock cycles each digit is displayed. Must be ≥1.
- LEAD_BLANK, 1: 1 blanks leading zero digits; digit 0 is never blanked.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  captures bcd_in into the shadow register on this edge.
- bcd_in  in  4*DIGITS  packed BCD value; digit i = bcd_in[4i+3:4i]; digit 0 is least significant.
- digit_sel  out  DIGITS  one-hot; bit i selects digit i.
- dec_out  out  10  one-hot decode of the displayed digit; bit n set for value n.
- invalid  out  1  displayed digit holds code 10..15.
- err_flag  out  1  any shadow digit holds code 10..15.
- frame_done  out  1  one-cycle pulse on the final cycle of each full scan.

Behaviour:
- Reset is one clock, asynchronous and active-low.
  - While rst_n=0: shadow=0, idx=0, cnt=0.
  - While rst_n=0, every output is 0: digit_sel, dec_out, invalid, err_flag, frame_done.
  - Reset takes effect immediately, including mid-scan or mid-load. Scanning restarts from digit 0.
- Capture: at a rising edge with load=1, shadow <= bcd_in. There is no handshake; load is honoured on every cycle it is high.
- Scan counter, evaluated every edge:
  - If cnt==SCAN_DIV-1: cnt <= 0 and idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - Otherwise: cnt <= cnt+1.
- Outputs are registered from the pre-edge idx and shadow:
  - digit_sel <= 1<<idx.
  - dec_out <= decode(shadow digit idx).
  - invalid <= (digit>9).
  - err_flag <= OR over all shadow digits of (digit>9).
- Latency:
  - Output changes 1 cycle after an idx change.
  - A loaded value appears on the outputs 2 edges after the load edge (the load edge plus one).
  - The first edge after reset release gives digit_sel=1 and dec_out=10'h001.
- Each digit is held for exactly SCAN_DIV cycles, so one full scan takes DIGITS*SCAN_DIV cycles.
- Decode: codes 0..9 give exactly one dec_out bit. Codes 10..15 give dec_out=0 and invalid=1.
- Leading blank (LEAD_BLANK=1): digit i>0 is blanked when digits i..DIGITS-1 are all 0.
  - A blanked digit gives dec_out=0 and invalid=0. digit_sel still advances.
  - An invalid code counts as non-zero for blanking purposes.
- frame_done <= (cnt==SCAN_DIV-1 && idx==DIGITS-1).
  - It is high during the last display cycle of digit DIGITS-1, once per scan.
- Simultaneous load and digit advance: both take effect. The next output uses the old shadow; the following output uses the new shadow.
- DIGITS=1: digit_sel is constantly 1 after reset, and frame_done pulses every SCAN_DIV cycles.
- SCAN_DIV=1: cnt is constant 0, and idx advances every cycle.
- cnt and idx widths are $clog2 of their range, minimum 1 bit. They never exceed their terminal value.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=4, LEAD_BLANK=1 unless stated.
1. Reset: hold rst_n=0, then release it. All outputs are 0 during reset; the first edge after release gives digit_sel=4'b0001 and dec_out=10'h001.
2. Load 16'h1234: dec_out shows 10'h010, 10'h008, 10'h004, 10'h002 for digits 0..3. Each is held 4 cycles with digit_sel 0001/0010/0100/1000. frame_done pulses once every 16 cycles, on the last digit-3 cycle.
3. Load 16'h0050: digit0 dec=10'h001, digit1 dec=10'h020, digits 2 and 3 dec=0 with invalid=0. With LEAD_BLANK=0, digits 2 and 3 show 10'h001.
4. Load 16'h1A03: while digit 2 is displayed, invalid=1 and dec_out=0, and err_flag=1 persistently. Loading 16'h0000 clears err_flag 2 edges later.
5. Pulse rst_n low mid-scan (digit 2, cnt=1): outputs go to 0 asynchronously. After release, scanning restarts at digit 0 with shadow=0.
6. Corner configurations: SCAN_DIV=1 gives digit_sel rotating every cycle with frame_done every 4 cycles. DIGITS=1 with SCAN_DIV=3 gives frame_done every 3 cycles.

Source files
------------

// File: rtl/bcd_scan_decoder.sv
// bcd_scan_decoder
//   Time-multiplexed multi-digit BCD decoder. A packed BCD word is captured
//   into a shadow register. The digits are then scanned one at a time, each
//   for SCAN_DIV cycles. For the digit on display the block drives a one-hot
//   digit select and a one-hot 0..9 decode. It also flags invalid codes and
//   can blank leading zeros.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       capture bcd_in into the shadow register on this edge
//   bcd_in     packed BCD value, digit i = bcd_in[4i+3:4i]
//   digit_sel  one-hot digit select, bit i selects digit i
//   dec_out    one-hot decode of the displayed digit (bit n for value n)
//   invalid    displayed digit holds code 10..15
//   err_flag   any shadow digit holds code 10..15
//   frame_done one-cycle pulse on the final cycle of each full scan
module bcd_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 16,
    parameter int LEAD_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [9:0]            dec_out,
    output logic                  invalid,
    output logic                  err_flag,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;

    logic [3:0]          cur_digit;
    logic                cur_blank;
    logic [DIGITS-1:0]   upper_zero;   // bit i: digits i..DIGITS-1 are all zero
    logic                zero_run;
    logic                any_bad;
    logic [DIGITS-1:0]   sel_next;
    logic [9:0]          dec_next;
    logic                invalid_next;
    logic                frame_next;
    logic                cnt_wrap;

    assign cnt_wrap   = (cnt == CNT_LAST);
    assign frame_next = cnt_wrap && (idx == IDX_LAST);

    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cur_digit    = '0;
        cur_blank    = 1'b0;
        upper_zero   = '0;
        zero_run     = 1'b1;
        any_bad      = 1'b0;
        sel_next     = '0;
        dec_next     = '0;
        invalid_next = 1'b0;

        // Walk from the most significant digit down. The zero run breaks at
        // the first non-zero code. Invalid codes are non-zero, so they also
        // stop blanking.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (shadow[4*i +: 4] == 4'd0);
            upper_zero[i] = zero_run;
            any_bad       = any_bad || (shadow[4*i +: 4] > 4'd9);
        end

        for (int i = 0; i < DIGITS; i++) begin
            sel_next[i] = (idx == IDX_W'(i));
            if (idx == IDX_W'(i)) begin
                cur_digit = shadow[4*i +: 4];
                cur_blank = (LEAD_BLANK != 0) && (i != 0) && upper_zero[i];
            end
        end

        for (int n = 0; n < 10; n++) begin
            dec_next[n] = (cur_digit == 4'(n)) && !cur_blank;
        end
        invalid_next = (cur_digit > 4'd9) && !cur_blank;
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    // All registers then sample pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            cnt        <= '0;
            idx        <= '0;
            digit_sel  <= '0;
            dec_out    <= '0;
            invalid    <= 1'b0;
            err_flag   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                shadow <= bcd_in;
            end

            if (cnt_wrap) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            digit_sel  <= sel_next;
            dec_out    <= dec_next;
            invalid    <= invalid_next;
            err_flag   <= any_bad;
            frame_done <= frame_next;
        end
    end

endmodule
